mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
Multi-cycle control sequencer for the MIPS-subset CPU. It replaces single-cycle decode with a registered state machine that steps the shared datapath through fetch, decode, execute, memory and write-back. It drives a single unified memory port through a req/ready handshake and produces every datapath mux select and write strobe. The ALU op codes use the existing 4-bit ALU_op encoding: R_TYPE=0, ADDI=1, SLTIU=2, BEQ=3, LUI=4, ORI=5, BNE=6, LW=7, SW=8, J=12, JAL=13.

Parameters:
ST_W, 4, width of state register and state_o
JR_FUNCT, 6'b001000, funct code decoded as jr under opcode 000000

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, synchronous, active-low
instr_op_i  input  6  IR[31:26]
funct_i  input  6  IR[5:0]
zero_i  input  1  ALU zero flag, current cycle
mem_ready_i  input  1  memory accepts/completes access this cycle
mem_req_o  output  1  memory access request
mem_we_o  output  1  1=write, qualified by mem_req_o
iord_o  output  1  address select: 0=PC, 1=ALUOut
ir_write_o  output  1  load IR
mdr_write_o  output  1  load MDR
pc_write_o  output  1  load PC
pc_source_o  output  2  0=ALU result, 1=ALUOut, 2=jump target, 3=rs
alu_src_a_o  output  1  0=PC, 1=reg A
alu_src_b_o  output  2  0=reg B, 1=const 4, 2=ext imm, 3=ext imm<<2
ext_zero_o  output  1  1=zero-extend imm (ori), 0=sign-extend
ALU_op_o  output  4  ALU op code, encoding above
reg_write_o  output  1  register file write
reg_dst_o  output  2  0=rt, 1=rd, 2=$31
mem_to_reg_o  output  2  0=ALUOut, 1=MDR, 2=PC
instr_done_o  output  1  one-cycle pulse on final cycle of each instruction
illegal_o  output  1  sticky illegal-opcode flag
state_o  output  ST_W  current state code

Behaviour:
- State register only; all outputs are combinational from state, opcode, funct, zero_i and mem_ready_i. While rst_n=0, every output is forced 0. On the first edge with rst_n=0, the state becomes FETCH.
- Outputs not listed for a state are 0. The default ALU_op_o is ADDI.
- FETCH(0): mem_req_o=1, iord_o=0, alu_src_a_o=0, alu_src_b_o=1. Hold until mem_ready_i=1. In the ready cycle, ir_write_o=1, pc_write_o=1 and pc_source_o=0; next state is DECODE.
- DECODE(1): alu_src_a_o=0, alu_src_b_o=3, which latches the branch target into ALUOut. Dispatch:
  - 000000: JR if funct_i=JR_FUNCT, otherwise EXEC_R.
  - 001000, 001011, 001111, 001101: EXEC_I.
  - 100011 (lw), 101011 (sw): ADDR.
  - 000100, 000101: BRANCH.
  - 000010, 000011: JUMP.
  - Anything else: ILLEGAL.
- EXEC_R(2): alu_src_a_o=1, alu_src_b_o=0, ALU_op_o=R_TYPE. Next state is WB_R.
- WB_R(3): reg_write_o=1, reg_dst_o=1, mem_to_reg_o=0, instr_done_o=1. Next state is FETCH.
- EXEC_I(4): alu_src_a_o=1, alu_src_b_o=2. ALU_op_o is ADDI, SLTIU, LUI or ORI per opcode. ext_zero_o=1 only for ori. Next state is WB_I.
- WB_I(5): reg_write_o=1, reg_dst_o=0, mem_to_reg_o=0, instr_done_o=1. Next state is FETCH. ext_zero_o and ALU_op_o are held as in EXEC_I.
- ADDR(6): alu_src_a_o=1, alu_src_b_o=2, ALU_op_o=LW or SW. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD(7): mem_req_o=1, iord_o=1. Hold until mem_ready_i. In the ready cycle, mdr_write_o=1; next state is WB_MEM.
- MEM_WR(8): mem_req_o=1, mem_we_o=1, iord_o=1. Hold until mem_ready_i. In the ready cycle, instr_done_o=1; next state is FETCH.
- WB_MEM(9): reg_write_o=1, reg_dst_o=0, mem_to_reg_o=1, instr_done_o=1. Next state is FETCH.
- BRANCH(10): alu_src_a_o=1, alu_src_b_o=0, ALU_op_o=BEQ or BNE, pc_source_o=1.
  - beq: pc_write_o=zero_i.
  - bne: pc_write_o=~zero_i.
  - instr_done_o=1; next state is FETCH.
- JUMP(11): pc_write_o=1, pc_source_o=2, ALU_op_o=J or JAL.
  - jal also asserts reg_write_o=1, reg_dst_o=2, mem_to_reg_o=2; the PC already holds PC+4.
  - instr_done_o=1; next state is FETCH.
- JR(12): pc_write_o=1, pc_source_o=3, instr_done_o=1. Next state is FETCH.
- ILLEGAL(13): behaviour per the optional feature.
- Codes 14 and 15 are unreachable and return to FETCH with no strobes.
- Memory handshake: mem_req_o and mem_we_o stay stable while waiting. There is no timeout. mem_ready_i is ignored in states that do not request.
- Latency with zero-wait memory:
  - R-type and I-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - branch, j, jal, jr: 3 cycles.
  - Each memory wait cycle adds 1.
- Reset mid-operation: a pending memory request is dropped at once (mem_req_o=0 while rst_n=0). The partially executed instruction leaves no further strobes.

Optional Feature:
MC_ILLEGAL_TRAP_EN:
- Defined: ILLEGAL is terminal. All strobes are 0, illegal_o=1, and the state stays at 13 until reset.
- Undefined: ILLEGAL acts as a NOP. It asserts instr_done_o=1 and goes to FETCH. illegal_o is tied to 0.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles in any state, then release -> state_o=0, mem_req_o=1, iord_o=0. While rst_n=0, every output is 0.
- add (op 000000, funct 100000) with mem_ready_i always 1 -> states 0,1,2,3. reg_write_o=1 and reg_dst_o=1 only in state 3. instr_done_o pulses exactly once, 4 cycles after the fetch start.
- lw (op 100011) with mem_ready_i low for 2 cycles in MEM_RD -> states 0,1,6,7,7,7,9. mdr_write_o pulses once, on the third cycle of state 7. WB_MEM shows mem_to_reg_o=1.
- beq (op 000100):
  - zero_i=1 -> state 10 with pc_write_o=1, pc_source_o=1.
  - Repeat with zero_i=0 -> pc_write_o=0.
  - bne with zero_i=0 -> pc_write_o=1.
- jal (op 000011) -> state 11 with pc_write_o=1, pc_source_o=2, reg_write_o=1, reg_dst_o=2, mem_to_reg_o=2, ALU_op_o=13.
- Illegal op 111111:
  - With MC_ILLEGAL_TRAP_EN: state_o=13 held for 10+ cycles and illegal_o=1; a reset clears it.
  - Without the macro: instr_done_o pulses and the state returns to 0.

Source files
------------

// File: rtl/mc_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_fsm_if
// Description : Control/datapath bundle between the multi-cycle sequencer and
//               the shared datapath plus unified memory port.
//               master = sequencer side, slave = datapath/memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_ctrl_fsm_if #(
    parameter int ST_W = 4
);
    // Instruction fields and datapath status
    logic [5:0]      instr_op_i;
    logic [5:0]      funct_i;
    logic            zero_i;
    logic            mem_ready_i;
    // Memory port control
    logic            mem_req_o;
    logic            mem_we_o;
    logic            iord_o;
    // Datapath register strobes and mux selects
    logic            ir_write_o;
    logic            mdr_write_o;
    logic            pc_write_o;
    logic [1:0]      pc_source_o;
    logic            alu_src_a_o;
    logic [1:0]      alu_src_b_o;
    logic            ext_zero_o;
    logic [3:0]      ALU_op_o;
    logic            reg_write_o;
    logic [1:0]      reg_dst_o;
    logic [1:0]      mem_to_reg_o;
    // Status
    logic            instr_done_o;
    logic            illegal_o;
    logic [ST_W-1:0] state_o;

    modport master (
        input  instr_op_i, funct_i, zero_i, mem_ready_i,
        output mem_req_o, mem_we_o, iord_o, ir_write_o, mdr_write_o,
               pc_write_o, pc_source_o, alu_src_a_o, alu_src_b_o, ext_zero_o,
               ALU_op_o, reg_write_o, reg_dst_o, mem_to_reg_o, instr_done_o,
               illegal_o, state_o
    );

    modport slave (
        output instr_op_i, funct_i, zero_i, mem_ready_i,
        input  mem_req_o, mem_we_o, iord_o, ir_write_o, mdr_write_o,
               pc_write_o, pc_source_o, alu_src_a_o, alu_src_b_o, ext_zero_o,
               ALU_op_o, reg_write_o, reg_dst_o, mem_to_reg_o, instr_done_o,
               illegal_o, state_o
    );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_fsm
// Description : Multi-cycle control sequencer for the MIPS-subset CPU. Steps
//               the shared datapath through fetch/decode/execute/memory/
//               write-back and drives the unified memory req/ready port.
//               Optional macro MC_ILLEGAL_TRAP_EN: when defined an illegal
//               opcode parks the sequencer in ILLEGAL until reset; otherwise
//               an illegal opcode retires as a NOP.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl_fsm #(
    parameter int         ST_W     = 4,
    parameter logic [5:0] JR_FUNCT = 6'b001000
) (
    input  logic          clk,
    input  logic          rst_n,
    mc_ctrl_fsm_if.master bus
);

    // Existing 4-bit ALU op encoding
    localparam logic [3:0] ALU_RTYPE = 4'd0;
    localparam logic [3:0] ALU_ADDI  = 4'd1;
    localparam logic [3:0] ALU_SLTIU = 4'd2;
    localparam logic [3:0] ALU_BEQ   = 4'd3;
    localparam logic [3:0] ALU_LUI   = 4'd4;
    localparam logic [3:0] ALU_ORI   = 4'd5;
    localparam logic [3:0] ALU_BNE   = 4'd6;
    localparam logic [3:0] ALU_LW    = 4'd7;
    localparam logic [3:0] ALU_SW    = 4'd8;
    localparam logic [3:0] ALU_J     = 4'd12;
    localparam logic [3:0] ALU_JAL   = 4'd13;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [ST_W-1:0] {
        FETCH   = ST_W'(0),
        DECODE  = ST_W'(1),
        EXEC_R  = ST_W'(2),
        WB_R    = ST_W'(3),
        EXEC_I  = ST_W'(4),
        WB_I    = ST_W'(5),
        ADDR    = ST_W'(6),
        MEM_RD  = ST_W'(7),
        MEM_WR  = ST_W'(8),
        WB_MEM  = ST_W'(9),
        BRANCH  = ST_W'(10),
        JUMP    = ST_W'(11),
        JR      = ST_W'(12),
        ILLEGAL = ST_W'(13)
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] imm_alu_op;

    // State register; reset always restarts at instruction fetch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // ALU op for immediate-format instructions, shared by EXEC_I and WB_I
    // (IR is stable across both, so the op is simply re-decoded)
    always_comb begin
        imm_alu_op = ALU_ADDI;
        case (bus.instr_op_i)
            OP_SLTIU: imm_alu_op = ALU_SLTIU;
            OP_LUI:   imm_alu_op = ALU_LUI;
            OP_ORI:   imm_alu_op = ALU_ORI;
            default:  imm_alu_op = ALU_ADDI;
        endcase
    end

    // Next-state decode and all datapath controls; outputs are forced low in reset
    always_comb begin
        next_state        = state;
        bus.mem_req_o     = 1'b0;
        bus.mem_we_o      = 1'b0;
        bus.iord_o        = 1'b0;
        bus.ir_write_o    = 1'b0;
        bus.mdr_write_o   = 1'b0;
        bus.pc_write_o    = 1'b0;
        bus.pc_source_o   = 2'd0;
        bus.alu_src_a_o   = 1'b0;
        bus.alu_src_b_o   = 2'd0;
        bus.ext_zero_o    = 1'b0;
        bus.ALU_op_o      = ALU_ADDI;
        bus.reg_write_o   = 1'b0;
        bus.reg_dst_o     = 2'd0;
        bus.mem_to_reg_o  = 2'd0;
        bus.instr_done_o  = 1'b0;
        bus.illegal_o     = 1'b0;
        bus.state_o       = state;

        if (!rst_n) begin
            next_state   = FETCH;
            bus.ALU_op_o = ALU_RTYPE;
            bus.state_o  = '0;
        end else begin
            case (state)
                FETCH: begin
                    bus.mem_req_o   = 1'b1;
                    bus.alu_src_b_o = 2'd1;
                    if (bus.mem_ready_i) begin
                        bus.ir_write_o = 1'b1;
                        bus.pc_write_o = 1'b1;
                        next_state     = DECODE;
                    end
                end
                DECODE: begin
                    // PC + (imm << 2) is computed here so branches find it in ALUOut
                    bus.alu_src_b_o = 2'd3;
                    case (bus.instr_op_i)
                        OP_RTYPE:                         next_state = (bus.funct_i == JR_FUNCT) ? JR : EXEC_R;
                        OP_ADDI, OP_SLTIU, OP_LUI, OP_ORI: next_state = EXEC_I;
                        OP_LW, OP_SW:                     next_state = ADDR;
                        OP_BEQ, OP_BNE:                   next_state = BRANCH;
                        OP_J, OP_JAL:                     next_state = JUMP;
                        default:                          next_state = ILLEGAL;
                    endcase
                end
                EXEC_R: begin
                    bus.alu_src_a_o = 1'b1;
                    bus.ALU_op_o    = ALU_RTYPE;
                    next_state      = WB_R;
                end
                WB_R: begin
                    bus.reg_write_o  = 1'b1;
                    bus.reg_dst_o    = 2'd1;
                    bus.instr_done_o = 1'b1;
                    next_state       = FETCH;
                end
                EXEC_I: begin
                    bus.alu_src_a_o = 1'b1;
                    bus.alu_src_b_o = 2'd2;
                    bus.ALU_op_o    = imm_alu_op;
                    bus.ext_zero_o  = (bus.instr_op_i == OP_ORI);
                    next_state      = WB_I;
                end
                WB_I: begin
                    bus.reg_write_o  = 1'b1;
                    bus.ALU_op_o     = imm_alu_op;
                    bus.ext_zero_o   = (bus.instr_op_i == OP_ORI);
                    bus.instr_done_o = 1'b1;
                    next_state       = FETCH;
                end
                ADDR: begin
                    bus.alu_src_a_o = 1'b1;
                    bus.alu_src_b_o = 2'd2;
                    bus.ALU_op_o    = (bus.instr_op_i == OP_LW) ? ALU_LW : ALU_SW;
                    next_state      = (bus.instr_op_i == OP_LW) ? MEM_RD : MEM_WR;
                end
                MEM_RD: begin
                    bus.mem_req_o = 1'b1;
                    bus.iord_o    = 1'b1;
                    if (bus.mem_ready_i) begin
                        bus.mdr_write_o = 1'b1;
                        next_state      = WB_MEM;
                    end
                end
                MEM_WR: begin
                    bus.mem_req_o = 1'b1;
                    bus.mem_we_o  = 1'b1;
                    bus.iord_o    = 1'b1;
                    if (bus.mem_ready_i) begin
                        bus.instr_done_o = 1'b1;
                        next_state       = FETCH;
                    end
                end
                WB_MEM: begin
                    bus.reg_write_o  = 1'b1;
                    bus.mem_to_reg_o = 2'd1;
                    bus.instr_done_o = 1'b1;
                    next_state       = FETCH;
                end
                BRANCH: begin
                    bus.alu_src_a_o  = 1'b1;
                    bus.pc_source_o  = 2'd1;
                    bus.instr_done_o = 1'b1;
                    if (bus.instr_op_i == OP_BEQ) begin
                        bus.ALU_op_o   = ALU_BEQ;
                        bus.pc_write_o = bus.zero_i;
                    end else begin
                        bus.ALU_op_o   = ALU_BNE;
                        bus.pc_write_o = ~bus.zero_i;
                    end
                    next_state = FETCH;
                end
                JUMP: begin
                    bus.pc_write_o   = 1'b1;
                    bus.pc_source_o  = 2'd2;
                    bus.instr_done_o = 1'b1;
                    if (bus.instr_op_i == OP_JAL) begin
                        // PC already holds the return address (PC+4) from FETCH
                        bus.ALU_op_o     = ALU_JAL;
                        bus.reg_write_o  = 1'b1;
                        bus.reg_dst_o    = 2'd2;
                        bus.mem_to_reg_o = 2'd2;
                    end else begin
                        bus.ALU_op_o     = ALU_J;
                    end
                    next_state = FETCH;
                end
                JR: begin
                    bus.pc_write_o   = 1'b1;
                    bus.pc_source_o  = 2'd3;
                    bus.instr_done_o = 1'b1;
                    next_state       = FETCH;
                end
                ILLEGAL: begin
`ifdef MC_ILLEGAL_TRAP_EN
                    bus.illegal_o    = 1'b1;
                    next_state       = ILLEGAL;
`else
                    bus.instr_done_o = 1'b1;
                    next_state       = FETCH;
`endif
                end
                default: begin
                    next_state = FETCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_ctrl_fsm
// Description : Self-checking bench for mc_ctrl_fsm. Per-cycle stimulus and
//               expected control snapshots are queued together; each cycle
//               the snapshot is popped and compared against the DUT outputs.
//               Honours MC_ILLEGAL_TRAP_EN for the illegal-opcode scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic [3:0] state;
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       mdr_write;
        logic       pc_write;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [3:0] alu_op;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       instr_done;
        logic       illegal;
    } snap_t;

    typedef struct packed {
        logic       rst_n;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic       ready;
    } stim_t;

    logic clk;
    logic rst_n;

    stim_t stim_q[$];
    snap_t sb[$];
    int    total;
    int    bad;

    mc_ctrl_fsm_if #(.ST_W(4)) bus ();

    mc_ctrl_fsm #(
        .ST_W     (4),
        .JR_FUNCT (6'b001000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(input logic r, input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic rdy);
        stim_t s;
        s.rst_n = r; s.op = op; s.funct = fn; s.zero = z; s.ready = rdy;
        return s;
    endfunction

    function automatic snap_t idle(input logic [3:0] st);
        snap_t e;
        e = '0;
        e.state  = st;
        e.alu_op = 4'd1;
        return e;
    endfunction

    function automatic snap_t exp_fetch(input logic ready);
        snap_t e;
        e = idle(4'd0);
        e.mem_req   = 1'b1;
        e.alu_src_b = 2'd1;
        if (ready) begin
            e.ir_write = 1'b1;
            e.pc_write = 1'b1;
        end
        return e;
    endfunction

    function automatic snap_t exp_decode();
        snap_t e;
        e = idle(4'd1);
        e.alu_src_b = 2'd3;
        return e;
    endfunction

    function automatic snap_t sample();
        snap_t g;
        g.state      = bus.state_o;
        g.mem_req    = bus.mem_req_o;
        g.mem_we     = bus.mem_we_o;
        g.iord       = bus.iord_o;
        g.ir_write   = bus.ir_write_o;
        g.mdr_write  = bus.mdr_write_o;
        g.pc_write   = bus.pc_write_o;
        g.pc_source  = bus.pc_source_o;
        g.alu_src_a  = bus.alu_src_a_o;
        g.alu_src_b  = bus.alu_src_b_o;
        g.ext_zero   = bus.ext_zero_o;
        g.alu_op     = bus.ALU_op_o;
        g.reg_write  = bus.reg_write_o;
        g.reg_dst    = bus.reg_dst_o;
        g.mem_to_reg = bus.mem_to_reg_o;
        g.instr_done = bus.instr_done_o;
        g.illegal    = bus.illegal_o;
        return g;
    endfunction

    task automatic push(input stim_t s, input snap_t e);
        stim_q.push_back(s);
        sb.push_back(e);
    endtask

    task automatic apply(input stim_t s);
        rst_n           = s.rst_n;
        bus.instr_op_i  = s.op;
        bus.funct_i     = s.funct;
        bus.zero_i      = s.zero;
        bus.mem_ready_i = s.ready;
    endtask

    task automatic test_reset();
        snap_t got, want;
        push(mk(1'b0, 6'b000100, 6'b111111, 1'b1, 1'b1), snap_t'('0));
        push(mk(1'b0, 6'b000100, 6'b111111, 1'b1, 1'b1), snap_t'('0));
        push(mk(1'b1, 6'b000000, 6'b000000, 1'b0, 1'b0), exp_fetch(1'b0));
        for (int k = 0; stim_q.size() > 0; k++) begin
            @(posedge clk); #1; apply(stim_q.pop_front());
            @(negedge clk);
            got = sample(); want = sb.pop_front(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset cyc%0d got=%h exp=%h", k, got, want);
            end
        end
    endtask

    task automatic test_add();
        snap_t got, want, e;
        stim_t s;
        s = mk(1'b1, 6'b000000, 6'b100000, 1'b0, 1'b1);
        push(s, exp_fetch(1'b1));
        push(s, exp_decode());
        e = idle(4'd2); e.alu_src_a = 1'b1; e.alu_op = 4'd0; push(s, e);
        e = idle(4'd3); e.reg_write = 1'b1; e.reg_dst = 2'd1; e.instr_done = 1'b1; push(s, e);
        for (int k = 0; stim_q.size() > 0; k++) begin
            @(posedge clk); #1; apply(stim_q.pop_front());
            @(negedge clk);
            got = sample(); want = sb.pop_front(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL add cyc%0d got=%h exp=%h", k, got, want);
            end
        end
    endtask

    task automatic test_lw_wait();
        snap_t got, want, e, rd;
        logic [5:0] op;
        op = 6'b100011;
        push(mk(1'b1, op, 6'd0, 1'b0, 1'b1), exp_fetch(1'b1));
        push(mk(1'b1, op, 6'd0, 1'b0, 1'b0), exp_decode());
        e = idle(4'd6); e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_op = 4'd7;
        push(mk(1'b1, op, 6'd0, 1'b0, 1'b1), e);
        rd = idle(4'd7); rd.mem_req = 1'b1; rd.iord = 1'b1;
        push(mk(1'b1, op, 6'd0, 1'b0, 1'b0), rd);
        push(mk(1'b1, op, 6'd0, 1'b0, 1'b0), rd);
        rd.mdr_write = 1'b1;
        push(mk(1'b1, op, 6'd0, 1'b0, 1'b1), rd);
        e = idle(4'd9); e.reg_write = 1'b1; e.mem_to_reg = 2'd1; e.instr_done = 1'b1;
        push(mk(1'b1, op, 6'd0, 1'b0, 1'b0), e);
        for (int k = 0; stim_q.size() > 0; k++) begin
            @(posedge clk); #1; apply(stim_q.pop_front());
            @(negedge clk);
            got = sample(); want = sb.pop_front(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL lw cyc%0d got=%h exp=%h", k, got, want);
            end
        end
    endtask

    task automatic test_sw_fetch_wait();
        snap_t got, want, e;
        logic [5:0] op;
        op = 6'b101011;
        push(mk(1'b1, op, 6'd0, 1'b0, 1'b0), exp_fetch(1'b0));
        push(mk(1'b1, op, 6'd0, 1'b0, 1'b1), exp_fetch(1'b1));
        push(mk(1'b1, op, 6'd0, 1'b0, 1'b1), exp_decode());
        e = idle(4'd6); e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_op = 4'd8;
        push(mk(1'b1, op, 6'd0, 1'b0, 1'b1), e);
        e = idle(4'd8); e.mem_req = 1'b1; e.mem_we = 1'b1; e.iord = 1'b1; e.instr_done = 1'b1;
        push(mk(1'b1, op, 6'd0, 1'b0, 1'b1), e);
        for (int k = 0; stim_q.size() > 0; k++) begin
            @(posedge clk); #1; apply(stim_q.pop_front());
            @(negedge clk);
            got = sample(); want = sb.pop_front(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL sw cyc%0d got=%h exp=%h", k, got, want);
            end
        end
    endtask

    task automatic test_branch();
        snap_t got, want, e;
        logic [5:0] op;
        logic       z;
        // beq z=1, beq z=0, bne z=0, bne z=1
        for (int v = 0; v < 4; v++) begin
            op = (v < 2) ? 6'b000100 : 6'b000101;
            z  = (v == 0 || v == 3);
            push(mk(1'b1, op, 6'd0, z, 1'b1), exp_fetch(1'b1));
            push(mk(1'b1, op, 6'd0, z, 1'b1), exp_decode());
            e = idle(4'd10); e.alu_src_a = 1'b1; e.pc_source = 2'd1; e.instr_done = 1'b1;
            e.alu_op   = (v < 2) ? 4'd3 : 4'd6;
            e.pc_write = (v == 0 || v == 2);
            push(mk(1'b1, op, 6'd0, z, 1'b1), e);
        end
        for (int k = 0; stim_q.size() > 0; k++) begin
            @(posedge clk); #1; apply(stim_q.pop_front());
            @(negedge clk);
            got = sample(); want = sb.pop_front(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL branch cyc%0d got=%h exp=%h", k, got, want);
            end
        end
    endtask

    task automatic test_jumps();
        snap_t got, want, e;
        stim_t s;
        // jal
        s = mk(1'b1, 6'b000011, 6'd0, 1'b0, 1'b1);
        push(s, exp_fetch(1'b1)); push(s, exp_decode());
        e = idle(4'd11); e.pc_write = 1'b1; e.pc_source = 2'd2; e.alu_op = 4'd13;
        e.reg_write = 1'b1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2; e.instr_done = 1'b1;
        push(s, e);
        // j
        s = mk(1'b1, 6'b000010, 6'd0, 1'b0, 1'b1);
        push(s, exp_fetch(1'b1)); push(s, exp_decode());
        e = idle(4'd11); e.pc_write = 1'b1; e.pc_source = 2'd2; e.alu_op = 4'd12; e.instr_done = 1'b1;
        push(s, e);
        // jr
        s = mk(1'b1, 6'b000000, 6'b001000, 1'b0, 1'b1);
        push(s, exp_fetch(1'b1)); push(s, exp_decode());
        e = idle(4'd12); e.pc_write = 1'b1; e.pc_source = 2'd3; e.instr_done = 1'b1;
        push(s, e);
        for (int k = 0; stim_q.size() > 0; k++) begin
            @(posedge clk); #1; apply(stim_q.pop_front());
            @(negedge clk);
            got = sample(); want = sb.pop_front(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL jump cyc%0d got=%h exp=%h", k, got, want);
            end
        end
    endtask

    task automatic test_imm();
        snap_t got, want, e;
        stim_t s;
        logic [5:0] ops [4];
        logic [3:0] alu [4];
        ops[0] = 6'b001101; alu[0] = 4'd5;   // ori
        ops[1] = 6'b001111; alu[1] = 4'd4;   // lui
        ops[2] = 6'b001011; alu[2] = 4'd2;   // sltiu
        ops[3] = 6'b001000; alu[3] = 4'd1;   // addi
        for (int v = 0; v < 4; v++) begin
            s = mk(1'b1, ops[v], 6'd0, 1'b0, 1'b1);
            push(s, exp_fetch(1'b1)); push(s, exp_decode());
            e = idle(4'd4); e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_op = alu[v];
            e.ext_zero = (v == 0);
            push(s, e);
            e = idle(4'd5); e.reg_write = 1'b1; e.alu_op = alu[v]; e.ext_zero = (v == 0);
            e.instr_done = 1'b1;
            push(s, e);
        end
        for (int k = 0; stim_q.size() > 0; k++) begin
            @(posedge clk); #1; apply(stim_q.pop_front());
            @(negedge clk);
            got = sample(); want = sb.pop_front(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL imm cyc%0d got=%h exp=%h", k, got, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        snap_t got, want, e;
        logic [5:0] op;
        op = 6'b100011;
        push(mk(1'b1, op, 6'd0, 1'b0, 1'b1), exp_fetch(1'b1));
        push(mk(1'b1, op, 6'd0, 1'b0, 1'b1), exp_decode());
        e = idle(4'd6); e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_op = 4'd7;
        push(mk(1'b1, op, 6'd0, 1'b0, 1'b0), e);
        e = idle(4'd7); e.mem_req = 1'b1; e.iord = 1'b1;
        push(mk(1'b1, op, 6'd0, 1'b0, 1'b0), e);
        push(mk(1'b0, op, 6'd0, 1'b0, 1'b1), snap_t'('0));
        push(mk(1'b0, op, 6'd0, 1'b0, 1'b1), snap_t'('0));
        push(mk(1'b1, op, 6'd0, 1'b0, 1'b0), exp_fetch(1'b0));
        for (int k = 0; stim_q.size() > 0; k++) begin
            @(posedge clk); #1; apply(stim_q.pop_front());
            @(negedge clk);
            got = sample(); want = sb.pop_front(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset_mid cyc%0d got=%h exp=%h", k, got, want);
            end
        end
    endtask

    task automatic test_illegal();
        snap_t got, want, e;
        stim_t s;
        s = mk(1'b1, 6'b111111, 6'd0, 1'b0, 1'b1);
        push(s, exp_fetch(1'b1));
        push(s, exp_decode());
`ifdef MC_ILLEGAL_TRAP_EN
        e = idle(4'd13); e.illegal = 1'b1;
        for (int c = 0; c < 12; c++) begin
            push(mk(1'b1, 6'b111111, 6'd0, c[0], c[1]), e);
        end
        push(mk(1'b0, 6'b111111, 6'd0, 1'b0, 1'b1), snap_t'('0));
        push(mk(1'b1, 6'b000000, 6'd0, 1'b0, 1'b0), exp_fetch(1'b0));
`else
        e = idle(4'd13); e.instr_done = 1'b1;
        push(s, e);
        push(mk(1'b1, 6'b000000, 6'd0, 1'b0, 1'b0), exp_fetch(1'b0));
`endif
        for (int k = 0; stim_q.size() > 0; k++) begin
            @(posedge clk); #1; apply(stim_q.pop_front());
            @(negedge clk);
            got = sample(); want = sb.pop_front(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL illegal cyc%0d got=%h exp=%h", k, got, want);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        apply(mk(1'b0, 6'b000100, 6'b111111, 1'b1, 1'b1));
        test_reset();
        test_add();
        test_lw_wait();
        test_sw_fetch_wait();
        test_branch();
        test_jumps();
        test_imm();
        test_reset_mid();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
